// File: rtl/vp_pkg.sv
// Shared definitions for the ROI video pipeline: mode encodings, luma
// coefficients and {R,G,B} pack/unpack helpers.
package vp_pkg;

    typedef enum logic [1:0] {
        MODE_PASS = 2'd0,
        MODE_GRAY = 2'd1,
        MODE_BIN  = 2'd2,
        MODE_INV  = 2'd3
    } mode_t;

    localparam int LUMA_R     = 77;
    localparam int LUMA_G     = 150;
    localparam int LUMA_B     = 29;
    localparam int LUMA_SHIFT = 8;

    // Helpers work on a fixed maximum channel width; callers size-cast in and out.
    localparam int CH_MAX = 16;
    localparam int PX_MAX = 3 * CH_MAX;

    // c selects the channel: 2 = R, 1 = G, 0 = B.
    function automatic logic [CH_MAX-1:0] px_chan(input logic [PX_MAX-1:0] px,
                                                  input int w, input int c);
        logic [PX_MAX-1:0] mask;
        mask = (PX_MAX'(1) << w) - PX_MAX'(1);
        return CH_MAX'((px >> (c * w)) & mask);
    endfunction

    function automatic logic [PX_MAX-1:0] px_pack(input logic [CH_MAX-1:0] r,
                                                  input logic [CH_MAX-1:0] g,
                                                  input logic [CH_MAX-1:0] b,
                                                  input int w);
        return (PX_MAX'(r) << (2 * w)) | (PX_MAX'(g) << w) | PX_MAX'(b);
    endfunction

endpackage

// File: rtl/vp_delay.sv
// Width/depth parametrised shift register with asynchronous reset.
module vp_delay #(
    parameter int W = 1,
    parameter int D = 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    logic [D-1:0][W-1:0] pipe;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pipe <= '0;
        end else begin
            pipe[0] <= d;
            for (int i = 1; i < D; i++) pipe[i] <= pipe[i-1];
        end
    end

    assign q = pipe[D-1];

endmodule

// File: rtl/vp_pipe.sv
// Pipelined pixel processor: per-frame shadowed mode/ROI, 3-cycle latency
// with de/h_sync/v_sync delayed to stay aligned with the pixel data.
module vp_pipe
    import vp_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int X_W    = 11,
    parameter int Y_W    = 11,
    parameter int LAT    = 3
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                de_in,
    input  logic                h_sync_in,
    input  logic                v_sync_in,
    input  logic [3*DATA_W-1:0] pixel_in,
    input  logic [1:0]          mode,
    input  logic [DATA_W-1:0]   threshold,
    input  logic [X_W-1:0]      roi_x0,
    input  logic [X_W-1:0]      roi_x1,
    input  logic [Y_W-1:0]      roi_y0,
    input  logic [Y_W-1:0]      roi_y1,
    output logic                de_out,
    output logic                h_sync_out,
    output logic                v_sync_out,
    output logic [3*DATA_W-1:0] pixel_out,
    output logic [X_W-1:0]      x_pos,
    output logic [Y_W-1:0]      y_pos
);

    localparam int PX_W  = 3 * DATA_W;
    localparam int PR_W  = DATA_W + 8;
    localparam int SUM_W = DATA_W + 10;
    localparam int BUS_W = PX_W + 1 + 2 + DATA_W;

    generate
        if (LAT != 3) begin : g_lat_chk
            $error("vp_pipe: LAT must be 3");
        end
        if (DATA_W > CH_MAX) begin : g_w_chk
            $error("vp_pipe: DATA_W exceeds package channel width");
        end
    endgenerate

    logic              de_prev, vs_prev;
    logic [1:0]        sh_mode;
    logic [DATA_W-1:0] sh_thr;
    logic [X_W-1:0]    sh_x0, sh_x1;
    logic [Y_W-1:0]    sh_y0, sh_y1;
    logic              vs_rise, de_fall, in_roi;

    assign vs_rise = v_sync_in & ~vs_prev;
    assign de_fall = de_prev & ~de_in;

    // Stage 0: input-timing position counters and frame-boundary config capture.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            de_prev <= 1'b0;
            vs_prev <= 1'b0;
            sh_mode <= MODE_PASS;
            sh_thr  <= '0;
            sh_x0   <= '0;
            sh_x1   <= '0;
            sh_y0   <= '0;
            sh_y1   <= '0;
            x_pos   <= '0;
            y_pos   <= '0;
        end else begin
            de_prev <= de_in;
            vs_prev <= v_sync_in;
            if (vs_rise) begin
                sh_mode <= mode;
                sh_thr  <= threshold;
                sh_x0   <= roi_x0;
                sh_x1   <= roi_x1;
                sh_y0   <= roi_y0;
                sh_y1   <= roi_y1;
            end
            if (de_in)        x_pos <= x_pos + X_W'(1);
            else if (de_fall) x_pos <= '0;
            if (vs_rise)      y_pos <= '0;
            else if (de_fall) y_pos <= y_pos + Y_W'(1);
        end
    end

    // An inverted bound (x0 > x1 or y0 > y1) can never satisfy both compares.
    assign in_roi = (x_pos >= sh_x0) && (x_pos <= sh_x1) &&
                    (y_pos >= sh_y0) && (y_pos <= sh_y1);

    logic [DATA_W-1:0] r_in, g_in, b_in;
    assign r_in = DATA_W'(px_chan(PX_MAX'(pixel_in), DATA_W, 2));
    assign g_in = DATA_W'(px_chan(PX_MAX'(pixel_in), DATA_W, 1));
    assign b_in = DATA_W'(px_chan(PX_MAX'(pixel_in), DATA_W, 0));

    logic [PR_W-1:0]   pr, pg, pb;
    logic [SUM_W-1:0]  sum;
    logic [DATA_W-1:0] y_s2;
    logic [PX_W-1:0]   px_s3, px_nxt;

    assign sum = SUM_W'(pr) + SUM_W'(pg) + SUM_W'(pb);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pr    <= '0;
            pg    <= '0;
            pb    <= '0;
            y_s2  <= '0;
            px_s3 <= '0;
        end else begin
            pr    <= PR_W'(LUMA_R) * PR_W'(r_in);
            pg    <= PR_W'(LUMA_G) * PR_W'(g_in);
            pb    <= PR_W'(LUMA_B) * PR_W'(b_in);
            y_s2  <= DATA_W'(sum >> LUMA_SHIFT);
            px_s3 <= px_nxt;
        end
    end

    // Original pixel, ROI flag and shadow mode/threshold ride alongside the luma math.
    logic [BUS_W-1:0]  s2_bus;
    logic [PX_W-1:0]   s2_px;
    logic              s2_roi;
    logic [1:0]        s2_mode;
    logic [DATA_W-1:0] s2_thr;

    vp_delay #(.W(BUS_W), .D(LAT-1)) u_px_dly (
        .clk (clk),
        .rst (rst),
        .d   ({pixel_in, in_roi, sh_mode, sh_thr}),
        .q   (s2_bus)
    );

    assign {s2_px, s2_roi, s2_mode, s2_thr} = s2_bus;

    always_comb begin
        px_nxt = s2_px;
        if (s2_roi) begin
            case (mode_t'(s2_mode))
                MODE_GRAY: px_nxt = PX_W'(px_pack(CH_MAX'(y_s2), CH_MAX'(y_s2),
                                                  CH_MAX'(y_s2), DATA_W));
                MODE_BIN:  px_nxt = (y_s2 > s2_thr) ? '1 : '0;
                MODE_INV:  px_nxt = ~s2_px;
                default:   px_nxt = s2_px;
            endcase
        end
    end

    vp_delay #(.W(3), .D(LAT)) u_sync_dly (
        .clk (clk),
        .rst (rst),
        .d   ({de_in, h_sync_in, v_sync_in}),
        .q   ({de_out, h_sync_out, v_sync_out})
    );

    assign pixel_out = de_out ? px_s3 : '0;

endmodule

// File: tb/tb_vp_pipe.sv
// Directed bench for vp_pipe: latency/alignment, gray, binary, ROI,
// config shadowing and asynchronous reset.
module tb_vp_pipe;

    logic        clk = 1'b0;
    logic        rst;
    logic        de_in, h_sync_in, v_sync_in;
    logic [23:0] pixel_in;
    logic [1:0]  mode;
    logic [7:0]  threshold;
    logic [10:0] roi_x0, roi_x1, roi_y0, roi_y1;
    logic        de_out, h_sync_out, v_sync_out;
    logic [23:0] pixel_out;
    logic [10:0] x_pos, y_pos;

    int total = 0;
    int bad   = 0;

    typedef struct packed {
        logic        de;
        logic        hs;
        logic        vs;
        logic [23:0] px;
    } exp_t;

    exp_t q[$];

    always #5 clk = ~clk;

    vp_pipe #(.DATA_W(8), .X_W(11), .Y_W(11), .LAT(3)) dut (
        .clk        (clk),
        .rst        (rst),
        .de_in      (de_in),
        .h_sync_in  (h_sync_in),
        .v_sync_in  (v_sync_in),
        .pixel_in   (pixel_in),
        .mode       (mode),
        .threshold  (threshold),
        .roi_x0     (roi_x0),
        .roi_x1     (roi_x1),
        .roi_y0     (roi_y0),
        .roi_y1     (roi_y1),
        .de_out     (de_out),
        .h_sync_out (h_sync_out),
        .v_sync_out (v_sync_out),
        .pixel_out  (pixel_out),
        .x_pos      (x_pos),
        .y_pos      (y_pos)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
        end
    endtask

    // Drive one input cycle at the falling edge; outputs seen here belong to
    // the cycle driven three ticks earlier.
    task automatic tick(input logic d, input logic h, input logic v,
                        input logic [23:0] px, input logic [23:0] exp_px);
        exp_t e;
        @(negedge clk);
        if (q.size() == 3) begin
            e = q.pop_front();
            chk("de_out", 32'(de_out), 32'(e.de));
            chk("hs_out", 32'(h_sync_out), 32'(e.hs));
            chk("vs_out", 32'(v_sync_out), 32'(e.vs));
            chk("pixel", 32'(pixel_out), 32'(e.px));
        end
        de_in = d; h_sync_in = h; v_sync_in = v; pixel_in = px;
        e.de = d; e.hs = h; e.vs = v; e.px = d ? exp_px : 24'h0;
        q.push_back(e);
    endtask

    task automatic vs_pulse();
        tick(0, 0, 1, 24'h0, 24'h0);
        tick(0, 0, 1, 24'h0, 24'h0);
        tick(0, 0, 0, 24'h0, 24'h0);
        tick(0, 0, 0, 24'h0, 24'h0);
    endtask

    task automatic blank(input int n);
        for (int i = 0; i < n; i++) tick(0, (i == 0), 0, 24'h0, 24'h0);
    endtask

    // One line of n identical pixels; columns xlo..xhi of a hit line expect alt.
    task automatic line(input int n, input logic [23:0] px, input logic [23:0] alt,
                        input int xlo, input int xhi, input bit hit, input int yexp);
        for (int i = 0; i < n; i++) begin
            tick(1, 0, 0, px, (hit && i >= xlo && i <= xhi) ? alt : px);
            chk("x_pos", 32'(x_pos), 32'(i));
            if (i == 0) chk("y_pos", 32'(y_pos), 32'(yexp));
        end
        blank(2);
    endtask

    task automatic set_cfg(input logic [1:0] m, input logic [7:0] t,
                           input int x0, input int x1, input int y0, input int y1);
        mode = m; threshold = t;
        roi_x0 = 11'(x0); roi_x1 = 11'(x1); roi_y0 = 11'(y0); roi_y1 = 11'(y1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [23:0] r;
        rst = 1'b1;
        de_in = 0; h_sync_in = 0; v_sync_in = 0; pixel_in = 24'h0;
        set_cfg(0, 0, 0, 0, 0, 0);
        repeat (2) @(negedge clk);
        chk("rst_de", 32'(de_out), 0);
        chk("rst_hs", 32'(h_sync_out), 0);
        chk("rst_vs", 32'(v_sync_out), 0);
        chk("rst_px", 32'(pixel_out), 0);
        chk("rst_x", 32'(x_pos), 0);
        chk("rst_y", 32'(y_pos), 0);
        rst = 1'b0;

        // Latency/alignment in default pass mode, sync edges included.
        vs_pulse();
        for (int i = 0; i < 16; i++) begin
            r = 24'($urandom());
            tick(1, 0, 0, r, r);
        end
        tick(0, 1, 0, 24'h0, 24'h0);
        tick(0, 1, 0, 24'h0, 24'h0);
        tick(0, 0, 0, 24'h0, 24'h0);
        for (int i = 0; i < 4; i++) begin
            r = 24'($urandom());
            tick(1, 0, 0, r, r);
        end
        blank(2);

        // Gray.
        set_cfg(1, 0, 0, 2047, 0, 2047);
        vs_pulse();
        tick(1, 0, 0, 24'hFF0000, 24'h4C4C4C);
        tick(1, 0, 0, 24'h00FF00, 24'h959595);
        tick(1, 0, 0, 24'hFFFFFF, 24'hFFFFFF);
        blank(2);

        // Binary, strict compare against 100.
        set_cfg(2, 100, 0, 2047, 0, 2047);
        vs_pulse();
        tick(1, 0, 0, 24'h808080, 24'hFFFFFF);
        tick(1, 0, 0, 24'h646464, 24'h000000);
        tick(1, 0, 0, 24'h656565, 24'hFFFFFF);
        blank(2);

        // ROI: invert only line 1, columns 2..3.
        set_cfg(3, 0, 2, 3, 1, 1);
        vs_pulse();
        line(5, 24'h123456, 24'hEDCBA9, 2, 3, 0, 0);
        line(5, 24'h123456, 24'hEDCBA9, 2, 3, 1, 1);
        line(5, 24'h123456, 24'hEDCBA9, 2, 3, 0, 2);

        // Inverted x bounds make an empty ROI.
        set_cfg(3, 0, 5, 2, 0, 2047);
        vs_pulse();
        line(6, 24'h123456, 24'hEDCBA9, 0, 5, 0, 0);

        // Shadowing: a mid-frame mode change waits for the next frame.
        set_cfg(0, 0, 0, 2047, 0, 2047);
        vs_pulse();
        tick(1, 0, 0, 24'h00FF00, 24'h00FF00);
        tick(1, 0, 0, 24'h00FF00, 24'h00FF00);
        mode = 2'd1;
        tick(1, 0, 0, 24'h00FF00, 24'h00FF00);
        tick(1, 0, 0, 24'h00FF00, 24'h00FF00);
        blank(2);
        vs_pulse();
        line(3, 24'h00FF00, 24'h959595, 0, 2047, 1, 0);

        // Asynchronous reset mid-line.
        tick(1, 0, 0, 24'h00FF00, 24'h959595);
        tick(1, 0, 0, 24'h00FF00, 24'h959595);
        tick(1, 0, 0, 24'h00FF00, 24'h959595);
        tick(1, 0, 0, 24'h00FF00, 24'h959595);
        @(negedge clk);
        rst = 1'b1;
        de_in = 0; h_sync_in = 0; v_sync_in = 0; pixel_in = 24'h0;
        #1;
        chk("arst_de", 32'(de_out), 0);
        chk("arst_px", 32'(pixel_out), 0);
        chk("arst_x", 32'(x_pos), 0);
        chk("arst_y", 32'(y_pos), 0);
        q.delete();
        @(negedge clk);
        rst = 1'b0;
        // Shadow config is back to pass after reset.
        line(4, 24'h00FF00, 24'h959595, 0, 2047, 0, 0);
        blank(4);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
